// File: rtl/dsp_stim_pkg.sv
// Shared definitions for the DSP stimulus/capture block: command and
// readback field positions, FSM state encoding and small phase helpers.
package dsp_stim_pkg;

    // Command word fields
    localparam int A_LSB    = 0;
    localparam int B_LSB    = 18;
    localparam int N_LSB    = 36;
    localparam int N_W      = 8;
    localparam int L_LSB    = 44;
    localparam int L_W      = 4;
    localparam int R_BIT    = 48;
    localparam int M_BIT    = 49;
    localparam int CTRL_LSB = 50;
    localparam int CTRL_W   = 14;

    // Readback word fields
    localparam int P_MAX    = 48;
    localparam int SEQ_LSB  = 48;
    localparam int OVR_BIT  = 62;
    localparam int BUSY_BIT = 63;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRST    = 3'd1,
        ST_APPLY   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4
    } state_e;

    // First phase after setup: CE burst if N>0, else wait, else straight to capture
    function automatic state_e run_phase(input logic [7:0] n, input logic [3:0] l);
        if (n != 8'd0) begin
            return ST_APPLY;
        end else if (l != 4'd0) begin
            return ST_WAIT;
        end else begin
            return ST_CAPTURE;
        end
    endfunction

    // Value the shared down-counter is loaded with for that first phase
    function automatic logic [7:0] run_count(input logic [7:0] n, input logic [3:0] l);
        if (n != 8'd0) begin
            return n;
        end else begin
            return {4'd0, l};
        end
    endfunction

endpackage

// File: rtl/dsp_stim_capture.sv
// DSP stimulus/capture engine behind the UART control block. Each accepted
// strobe applies operands, optionally resets the DSP, pulses CE N times,
// waits L cycles and captures the DSP result into a stable readback word.
// Optional feature macro: DSP_STIM_RAMP_EN (operand A ramps during CE burst).
module dsp_stim_capture
    import dsp_stim_pkg::*;
#(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 18,
    parameter int P_WIDTH   = 48,
    parameter int CMD_WIDTH = 64,
    parameter int RES_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 strobe,
    input  logic [CMD_WIDTH-1:0] cmd,
    output logic [RES_WIDTH-1:0] result,
    output logic                 busy,
    output logic [A_WIDTH-1:0]   dut_a,
    output logic [B_WIDTH-1:0]   dut_b,
    output logic                 dut_ce,
    output logic                 dut_rst,
    output logic [13:0]          dut_ctrl,
    input  logic [P_WIDTH-1:0]   dut_p
);

    state_e               state_r;
    logic [7:0]           cnt_r;
    logic [7:0]           n_r;
    logic [3:0]           l_r;
    logic                 ramp_r;
    logic [P_MAX-1:0]     p_r;
    logic [7:0]           seq_r;
    logic                 ovr_r;
    logic [A_WIDTH-1:0]   dut_a_r;
    logic [B_WIDTH-1:0]   dut_b_r;
    logic                 dut_ce_r;
    logic                 dut_rst_r;
    logic [CTRL_W-1:0]    dut_ctrl_r;

    logic [7:0]           cmd_n_s;
    logic [3:0]           cmd_l_s;
    logic                 ramp_req_s;
    logic [P_MAX-1:0]     p_ext_s;

    assign cmd_n_s = cmd[N_LSB +: N_W];
    assign cmd_l_s = cmd[L_LSB +: L_W];

`ifdef DSP_STIM_RAMP_EN
    assign ramp_req_s = cmd[M_BIT];
`else
    // cmd[49] is reserved in this build
    logic unused_m_s;
    assign unused_m_s = cmd[M_BIT];
    assign ramp_req_s = 1'b0;
`endif

    // Zero-extend the DSP result to the fixed 48-bit readback field
    always_comb begin
        p_ext_s              = '0;
        p_ext_s[P_WIDTH-1:0] = dut_p;
    end

    // Run sequencer: command latch, DSP drive, shared counter, capture and status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            n_r        <= 8'd0;
            l_r        <= 4'd0;
            ramp_r     <= 1'b0;
            p_r        <= '0;
            seq_r      <= 8'd0;
            ovr_r      <= 1'b0;
            dut_a_r    <= '0;
            dut_b_r    <= '0;
            dut_ce_r   <= 1'b0;
            dut_rst_r  <= 1'b0;
            dut_ctrl_r <= '0;
        end else begin
            // A strobe while a run is in flight is dropped but remembered
            if (strobe && (state_r != ST_IDLE)) begin
                ovr_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (strobe) begin
                        ovr_r      <= 1'b0;
                        dut_a_r    <= cmd[A_LSB +: A_WIDTH];
                        dut_b_r    <= cmd[B_LSB +: B_WIDTH];
                        dut_ctrl_r <= cmd[CTRL_LSB +: CTRL_W];
                        n_r        <= cmd_n_s;
                        l_r        <= cmd_l_s;
                        ramp_r     <= ramp_req_s;
                        if (cmd[R_BIT]) begin
                            state_r   <= ST_DRST;
                            dut_rst_r <= 1'b1;
                        end else begin
                            state_r  <= run_phase(cmd_n_s, cmd_l_s);
                            cnt_r    <= run_count(cmd_n_s, cmd_l_s);
                            dut_ce_r <= (cmd_n_s != 8'd0);
                        end
                    end
                end
                ST_DRST: begin
                    dut_rst_r <= 1'b0;
                    state_r   <= run_phase(n_r, l_r);
                    cnt_r     <= run_count(n_r, l_r);
                    dut_ce_r  <= (n_r != 8'd0);
                end
                ST_APPLY: begin
                    if (ramp_r) begin
                        dut_a_r <= dut_a_r + A_WIDTH'(1);
                    end
                    if (cnt_r == 8'd1) begin
                        dut_ce_r <= 1'b0;
                        cnt_r    <= {4'd0, l_r};
                        state_r  <= (l_r != 4'd0) ? ST_WAIT : ST_CAPTURE;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r <= 8'd1) begin
                        state_r <= ST_CAPTURE;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                ST_CAPTURE: begin
                    p_r     <= p_ext_s;
                    seq_r   <= seq_r + 8'd1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    dut_ce_r  <= 1'b0;
                    dut_rst_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = (state_r != ST_IDLE);
    assign result   = {busy, ovr_r, 6'd0, seq_r, p_r};
    assign dut_a    = dut_a_r;
    assign dut_b    = dut_b_r;
    assign dut_ce   = dut_ce_r;
    assign dut_rst  = dut_rst_r;
    assign dut_ctrl = dut_ctrl_r;

endmodule

// File: tb/tb_dsp_stim_capture.sv
// Directed bench for dsp_stim_capture: a table of single runs plus
// hand-written overrun, boundary, reset-abort, wrap and ramp sequences.
module tb_dsp_stim_capture;

    logic        clk;
    logic        reset_n;
    logic        strobe;
    logic [63:0] cmd;
    logic [63:0] result;
    logic        busy;
    logic [17:0] dut_a;
    logic [17:0] dut_b;
    logic        dut_ce;
    logic        dut_rst;
    logic [13:0] dut_ctrl;
    logic [47:0] model_p = 48'd0;

    int checks = 0;
    int errors = 0;
    int ce_cnt = 0;
    int rst_cnt = 0;
    int ramp_n = 0;
    logic [17:0] ramp_log [8];

    dsp_stim_capture dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .strobe   (strobe),
        .cmd      (cmd),
        .result   (result),
        .busy     (busy),
        .dut_a    (dut_a),
        .dut_b    (dut_b),
        .dut_ce   (dut_ce),
        .dut_rst  (dut_rst),
        .dut_ctrl (dut_ctrl),
        .dut_p    (model_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered multiplier standing in for the DSP under test
    always @(posedge clk) begin
        if (dut_rst) model_p <= 48'd0;
        else if (dut_ce) model_p <= 48'(dut_a) * 48'(dut_b);
    end

    // Count CE / reset cycles and log operand A on each CE cycle
    always @(negedge clk) begin
        if (dut_ce) ce_cnt = ce_cnt + 1;
        if (dut_rst) rst_cnt = rst_cnt + 1;
        if (dut_ce && ramp_n < 8) begin
            ramp_log[ramp_n] = dut_a;
            ramp_n = ramp_n + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [17:0] a;
        logic [17:0] b;
        logic [7:0]  n;
        logic [3:0]  l;
        logic        r;
        logic [13:0] ctrl;
        int          exp_ce;
        int          exp_rst;
        int          exp_busy;
        logic [47:0] exp_p;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [17:0] a, input logic [17:0] b,
                                       input logic [7:0] n, input logic [3:0] l,
                                       input logic r, input logic m, input logic [13:0] ctrl);
        return {ctrl, m, r, l, n, b, a};
    endfunction

    task automatic pulse(input logic [63:0] c);
        strobe = 1'b1;
        cmd    = c;
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic wait_idle(output int cyc, output bit stable);
        logic [62:0] snap;
        snap   = result[62:0];
        cyc    = 0;
        stable = 1'b1;
        while (busy === 1'b1 && cyc < 400) begin
            cyc = cyc + 1;
            if (result[62:0] !== snap) stable = 1'b0;
            @(negedge clk);
        end
        check("idle_reached", 64'(busy), 64'd0);
    endtask

    task automatic run(input logic [63:0] c, output int cyc, output bit stable);
        ce_cnt  = 0;
        rst_cnt = 0;
        pulse(c);
        wait_idle(cyc, stable);
    endtask

    int cyc;
    bit stable;
    logic [17:0] ramp_exp [4];
    logic [47:0] ramp_p;

    initial begin
        vecs[0] = '{18'd3,       18'd5,       8'd1, 4'd2, 1'b0, 14'h0123, 1, 0, 4, 48'd15};
        vecs[1] = '{18'd7,       18'd9,       8'd3, 4'd0, 1'b0, 14'h3FFF, 3, 0, 4, 48'd63};
        vecs[2] = '{18'd100,     18'd200,     8'd0, 4'd5, 1'b0, 14'h1555, 0, 0, 6, 48'd63};
        vecs[3] = '{18'd11,      18'd13,      8'd0, 4'd0, 1'b1, 14'h2AAA, 0, 1, 2, 48'd0};
        vecs[4] = '{18'd2,       18'h3FFFF,   8'd2, 4'd1, 1'b1, 14'h0001, 2, 1, 5, 48'h7FFFE};
        vecs[5] = '{18'h3FFFF,   18'h3FFFF,   8'd1, 4'd0, 1'b0, 14'h2000, 1, 0, 2, 48'hFFFF80001};
`ifdef DSP_STIM_RAMP_EN
        ramp_exp = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
        ramp_p   = 48'd1;
`else
        ramp_exp = '{18'h3FFFE, 18'h3FFFE, 18'h3FFFE, 18'h3FFFE};
        ramp_p   = 48'h3FFFE;
`endif

        reset_n = 1'b0;
        strobe  = 1'b0;
        cmd     = 64'd0;
        repeat (3) @(negedge clk);
        check("rst_result", result, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dut", {dut_a, dut_b, dut_ce, dut_rst, dut_ctrl}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Table of independent runs
        for (int i = 0; i < 6; i++) begin
            run(mk(vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].l, vecs[i].r, 1'b0, vecs[i].ctrl), cyc, stable);
            check($sformatf("v%0d_ce", i), 64'(ce_cnt), 64'(vecs[i].exp_ce));
            check($sformatf("v%0d_rst", i), 64'(rst_cnt), 64'(vecs[i].exp_rst));
            check($sformatf("v%0d_busy", i), 64'(cyc), 64'(vecs[i].exp_busy));
            check($sformatf("v%0d_p", i), 64'(result[47:0]), 64'(vecs[i].exp_p));
            check($sformatf("v%0d_seq", i), 64'(result[55:48]), 64'(i + 1));
            check($sformatf("v%0d_top", i), 64'(result[63:56]), 64'd0);
            check($sformatf("v%0d_stable", i), 64'(stable), 64'd1);
            check($sformatf("v%0d_ab", i), 64'({dut_a, dut_b}), 64'({vecs[i].a, vecs[i].b}));
            check($sformatf("v%0d_ctrl", i), 64'(dut_ctrl), 64'(vecs[i].ctrl));
        end

        // Strobe landing in the CAPTURE cycle counts as overrun
        pulse(mk(18'd4, 18'd4, 8'd0, 4'd0, 1'b0, 1'b0, 14'd0));
        pulse(mk(18'd8, 18'd8, 8'd0, 4'd0, 1'b0, 1'b0, 14'd0));
        check("capovr_busy", 64'(busy), 64'd0);
        check("capovr_flag", 64'(result[62]), 64'd1);
        check("capovr_seq", 64'(result[55:48]), 64'd7);
        check("capovr_a", 64'(dut_a), 64'd4);

        // Overrun during a long CE burst
        ce_cnt = 0;
        pulse(mk(18'd1, 18'd1, 8'd200, 4'd0, 1'b0, 1'b0, 14'd0));
        check("ovr_cleared", 64'(result[62]), 64'd0);
        repeat (4) @(negedge clk);
        pulse(mk(18'd9, 18'd9, 8'd1, 4'd0, 1'b0, 1'b0, 14'd0));
        wait_idle(cyc, stable);
        check("ovr_ce", 64'(ce_cnt), 64'd200);
        check("ovr_flag", 64'(result[62]), 64'd1);
        check("ovr_seq", 64'(result[55:48]), 64'd8);
        check("ovr_p", 64'(result[47:0]), 64'd1);
        check("ovr_a", 64'(dut_a), 64'd1);
        run(mk(18'd2, 18'd3, 8'd1, 4'd0, 1'b0, 1'b0, 14'd0), cyc, stable);
        check("ovr_clr_flag", 64'(result[62]), 64'd0);
        check("ovr_clr_p", 64'(result[47:0]), 64'd6);
        check("ovr_clr_seq", 64'(result[55:48]), 64'd9);

        // Longest run: DSP reset, 255 CE, 15 wait
        run(mk(18'd5, 18'd5, 8'd255, 4'd15, 1'b1, 1'b0, 14'd0), cyc, stable);
        check("max_latency", 64'(cyc + 1), 64'd273);
        check("max_ce", 64'(ce_cnt), 64'd255);
        check("max_rst", 64'(rst_cnt), 64'd1);
        check("max_p", 64'(result[47:0]), 64'd25);
        check("max_seq", 64'(result[55:48]), 64'd10);

        // Ramp mode request
        ramp_n = 0;
        run(mk(18'h3FFFE, 18'd1, 8'd4, 4'd0, 1'b0, 1'b1, 14'd0), cyc, stable);
        check("ramp_n", 64'(ramp_n), 64'd4);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("ramp_a%0d", j), 64'(ramp_log[j]), 64'(ramp_exp[j]));
        end
        check("ramp_p", 64'(result[47:0]), 64'(ramp_p));
        check("ramp_seq", 64'(result[55:48]), 64'd11);

        // Asynchronous reset in the middle of a CE burst
        pulse(mk(18'd1, 18'd1, 8'd50, 4'd0, 1'b0, 1'b0, 14'h3AA));
        repeat (10) @(negedge clk);
        check("abort_pre_busy", 64'(busy), 64'd1);
        check("abort_pre_ce", 64'(dut_ce), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_result", result, 64'd0);
        check("abort_dut", {dut_a, dut_b, dut_ce, dut_rst, dut_ctrl}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_nocap", result, 64'd0);

        // 256 back-to-back runs: sequence restarts at 1 and wraps to 0
        for (int k = 0; k < 256; k++) begin
            run(mk(18'd1, 18'd2, 8'd0, 4'd0, 1'b0, 1'b0, 14'd0), cyc, stable);
            if (k == 0) check("wrap_first", 64'(result[55:48]), 64'd1);
            if (k == 254) check("wrap_255", 64'(result[55:48]), 64'd255);
        end
        check("wrap_zero", 64'(result[55:48]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_stim_capture.md
Name: dsp_stim_capture

Overview:
- Sits directly downstream of the UART control block. Consumes its `strobe` and 64-bit command word, and produces the 64-bit word the control block shifts back out.
- On each strobe it applies operands to the DSP under test, pulses clock-enable for a programmed number of cycles, waits a programmed latency, then captures the DSP output.
- The captured result is presented, with status, as a stable readback word.

Parameters:
- A_WIDTH, 18, width of DUT operand A
- B_WIDTH, 18, width of DUT operand B
- P_WIDTH, 48, width of DUT result (≤ 48)
- CMD_WIDTH, 64, width of command word (matches control DOUT_WIDTH)
- RES_WIDTH, 64, width of readback word (matches control DIN_WIDTH)

Ports:
- clk  in  1  single system clock
- reset_n  in  1  asynchronous, active-low reset
- strobe  in  1  one-cycle start pulse from control; cmd is valid in the same cycle
- cmd  in  CMD_WIDTH  command word
- result  out  RES_WIDTH  readback word to control din
- busy  out  1  high while a run is in progress
- dut_a  out  A_WIDTH  DUT operand A
- dut_b  out  B_WIDTH  DUT operand B
- dut_ce  out  1  DUT clock enable
- dut_rst  out  1  DUT synchronous reset, active high
- dut_ctrl  out  14  static DUT mode bits
- dut_p  in  P_WIDTH  DUT result

Behaviour:
- Command fields:
  - a = cmd[17:0]
  - b = cmd[35:18]
  - N = cmd[43:36], number of CE cycles
  - L = cmd[47:44], wait cycles
  - R = cmd[48], DUT reset request
  - M = cmd[49], ramp mode (see Optional Feature)
  - dut_ctrl = cmd[63:50]
- Reset (async, reset_n=0):
  - state=IDLE.
  - All dut_* outputs = 0; busy = 0; result = 0.
  - Sequence counter = 0; overrun flag = 0.
  - Reset mid-run aborts the run immediately. No capture occurs.
- States: IDLE, DRST, APPLY, WAIT, CAPTURE.
- IDLE:
  - On strobe, latch all fields and busy<=1.
  - Drive dut_a/dut_b/dut_ctrl from the latched fields on the next cycle; they hold until the next accepted strobe.
  - Next state: DRST if R=1; else APPLY if N>0; else WAIT.
- DRST: dut_rst=1 for exactly 1 cycle. Next state: APPLY if N>0, else WAIT.
- APPLY:
  - dut_ce=1 for exactly N consecutive cycles; a down-counter is loaded with N.
  - After the last CE cycle, go to WAIT.
- WAIT:
  - Exactly L cycles with dut_ce=0; L=0 means zero cycles.
  - Next state: CAPTURE.
- CAPTURE (one cycle):
  - result[47:0] <= dut_p, zero-extended if P_WIDTH < 48.
  - result[55:48] <= sequence counter + 1, wrapping 255→0; the counter is updated too.
  - Next state: IDLE; busy<=0 at the same edge.
- result[61:56] is always 0.
- result[62] = sticky overrun flag:
  - Set when strobe arrives while busy=1; that strobe is otherwise ignored.
  - Cleared only when a strobe is accepted in IDLE.
- result[63] = busy, driven combinationally from the state register.
- Bits 62:0 change only at CAPTURE, at overrun set, or at overrun clear; the readback is stable during UART shift-out.
- Timing: worst case from strobe to busy=0 is 1+1+255+15+1 = 273 cycles. This is well below one UART byte time, so control's first data nibble always reads a completed result.
- Strobe in the same cycle as CAPTURE: busy is still 1, so it is treated as overrun.

Optional Feature:
- Macro: DSP_STIM_RAMP_EN.
- Defined:
  - When M=1, dut_a increments by 1 (mod 2^A_WIDTH) after each APPLY CE cycle, starting from a.
  - dut_b stays constant.
- Undefined:
  - M is ignored and dut_a is constant.
  - cmd[49] is treated as reserved.

Decomposition:
- Package dsp_stim_pkg holds:
  - field offset/width localparams (A_LSB, B_LSB, N_LSB, L_LSB, R_BIT, M_BIT, CTRL_LSB, SEQ_LSB, OVR_BIT, BUSY_BIT)
  - the state enum typedef
- No sub-module; a single FSM plus one shared 8-bit down-counter reused for the APPLY and WAIT phases.

Test Plan:
- Basic run: cmd a=3, b=5, N=1, L=2, R=0; DUT model P=a*b registered → dut_ce high exactly 1 cycle; capture 3 cycles later; result[47:0]=15, result[55:48]=1, busy back to 0.
- DUT reset: R=1, N=0, L=0 → dut_rst high 1 cycle; no dut_ce; result holds dut_p sampled 2 cycles after strobe; sequence counter=1.
- Overrun: second strobe 5 cycles into an N=200 run → ignored; result[62]=1 after the run; next accepted strobe clears it; the first run's CE count is exactly 200.
- Boundaries: N=255, L=15 → busy for exactly 273 cycles. Then 256 back-to-back runs → sequence counter wraps to 0.
- Reset mid-run: reset_n low during APPLY → all outputs 0 asynchronously; no capture; the next run reports sequence=1.
- Ramp (DSP_STIM_RAMP_EN): a=0x3FFFE, N=4, M=1 → dut_a sequence 3FFFE, 3FFFF, 00000, 00001. Without the macro, dut_a stays 3FFFE.
